sdc_lane_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one DATA_W-bit output lane among NUM_REQ requesters.
- Each requester presents a valid/ready stream with a burst "last" marker.
- A grant is locked for a whole burst, so bursts never interleave.
- Output is registered: a 1-deep output stage with a valid/ready handshake toward the consumer. It sits in front of the 4-lane x 4-bit passthrough datapath and selects which lane feeds it.

---
 rtl/sdc_lane_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_sdc_lane_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_lane_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdc_lane_rr_arbiter
//  Description : Round-robin arbiter sharing one registered output lane among
//                NUM_REQ valid/ready requesters. A grant is held for a whole
//                burst (up to the beat carrying req_last), so bursts never
//                interleave. The output is a 1-deep register stage that can
//                pass one beat per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdc_lane_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2,
   parameter int DATA_W  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic [IDX_W-1:0]           out_lane,
   output logic                       out_last,
   input  logic                       out_ready,
   output logic                       busy
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    w_rr_ptr_nxt;
   logic [IDX_W-1:0]    r_gnt_idx;
   logic [IDX_W-1:0]    w_gnt_idx_nxt;
   logic [IDX_W-1:0]    w_pick_idx;
   logic [IDX_W-1:0]    w_cand;

   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic [IDX_W-1:0]    r_out_lane;
   logic                r_out_last;

   logic [DATA_W-1:0]   w_beat_data;
   logic                w_beat_last;
   logic                w_beat_valid;
   logic                w_slot_free;
   logic                w_accept;

   // Pick the first valid requester at or after rr_ptr; walking the offsets
   // from highest to lowest lets the smallest offset win the last write.
   always_comb begin
      w_pick_idx = r_rr_ptr;
      w_cand     = r_rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_cand = r_rr_ptr + IDX_W'(k);
         if (req_valid[w_cand]) begin
            w_pick_idx = w_cand;
         end
      end
   end

   // Mux the granted requester's beat onto the internal beat bus.
   always_comb begin
      w_beat_data  = '0;
      w_beat_last  = 1'b0;
      w_beat_valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == r_gnt_idx) begin
            w_beat_data  = req_data[i*DATA_W +: DATA_W];
            w_beat_last  = req_last[i];
            w_beat_valid = req_valid[i];
         end
      end
   end

   // The output slot can take a beat when empty or being drained this cycle.
   assign w_slot_free = !r_out_valid || out_ready;
   assign w_accept    = (r_state == LOCK) && !rst && w_beat_valid && w_slot_free;

   // Only the locked requester may see ready, and never while reset is held.
   always_comb begin
      req_ready = '0;
      if ((r_state == LOCK) && !rst) begin
         req_ready[r_gnt_idx] = w_slot_free;
      end
   end

   // Next-state logic: arbitrate in IDLE, release the lock on the last beat.
   always_comb begin
      w_state_nxt   = r_state;
      w_rr_ptr_nxt  = r_rr_ptr;
      w_gnt_idx_nxt = r_gnt_idx;
      case (r_state)
         IDLE: begin
            if (|req_valid) begin
               w_gnt_idx_nxt = w_pick_idx;
               w_state_nxt   = LOCK;
            end
         end
         LOCK: begin
            if (w_accept && w_beat_last) begin
               w_state_nxt  = IDLE;
               w_rr_ptr_nxt = r_gnt_idx + IDX_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Arbiter state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rr_ptr  <= '0;
         r_gnt_idx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_rr_ptr  <= w_rr_ptr_nxt;
         r_gnt_idx <= w_gnt_idx_nxt;
      end
   end

   // Output stage: load on accept (replacing a beat being drained), else empty on out_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_lane  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_beat_data;
         r_out_lane  <= r_gnt_idx;
         r_out_last  <= w_beat_last;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_lane  = r_out_lane;
   assign out_last  = r_out_last;
   assign busy      = (r_state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_sdc_lane_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdc_lane_rr_arbiter
//  Description : Bench for sdc_lane_rr_arbiter. Per-lane beat queues feed the
//                requesters; a transaction-level model (owner, pointer, output
//                slot) predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdc_lane_rr_arbiter;
   localparam int N  = 4;
   localparam int DW = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [IW-1:0]   out_lane;
   logic            out_last;
   logic            out_ready;
   logic            busy;

   always #5 clk = ~clk;

   sdc_lane_rr_arbiter #(.NUM_REQ(N), .IDX_W(IW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_lane  (out_lane),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Requester beat queues: {last, data}
   logic [4:0] beat_mem [N][256];
   int         wr_cnt [N];
   int         rd_cnt [N];

   // Reference model state
   bit m_locked;
   int m_owner;
   int m_ptr;
   bit m_ov;
   int m_od;
   int m_ol;
   bit m_olast;

   // Observations from the last step and transfer log {last, lane, data}
   int         cyc;
   logic [N-1:0] obs_rdy;
   logic       obs_ov;
   logic       obs_busy;
   logic [DW-1:0] obs_od;
   logic [6:0] xlog[$];
   int         xcyc[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int lane, input int data, input bit last);
      beat_mem[lane][wr_cnt[lane] % 256] = {last, 4'(data)};
      wr_cnt[lane]++;
   endtask

   task automatic flush();
      for (int i = 0; i < N; i++) rd_cnt[i] = wr_cnt[i];
   endtask

   task automatic step(input bit r, input bit ordy, input logic [N-1:0] en);
      logic [N-1:0]    v;
      logic [N-1:0]    l;
      logic [N-1:0]    exp_rdy;
      logic [N*DW-1:0] d;
      logic [4:0]      h;
      bit              acc;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         h = (wr_cnt[i] != rd_cnt[i]) ? beat_mem[i][rd_cnt[i] % 256] : 5'b0;
         v[i] = en[i] && (wr_cnt[i] != rd_cnt[i]);
         d[i*DW +: DW] = h[3:0];
         l[i] = h[4];
      end
      rst = r; out_ready = ordy; req_valid = v; req_data = d; req_last = l;
      #1;
      exp_rdy = '0;
      if (!r && m_locked && (!m_ov || ordy)) exp_rdy[m_owner] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("out_data",  32'(out_data),  32'(m_od));
      chk("out_lane",  32'(out_lane),  32'(m_ol));
      chk("out_last",  32'(out_last),  32'(m_olast));
      chk("busy",      32'(busy),      32'(m_locked));
      obs_rdy = req_ready; obs_ov = out_valid; obs_busy = busy; obs_od = out_data;
      if (!r && m_ov && ordy) begin
         xlog.push_back({out_last, out_lane, out_data});
         xcyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      if (r) begin
         m_locked = 0; m_owner = 0; m_ptr = 0;
         m_ov = 0; m_od = 0; m_ol = 0; m_olast = 0;
      end else if (!m_locked) begin
         for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) begin
               m_owner  = (m_ptr + k) % N;
               m_locked = 1;
               break;
            end
         end
         if (ordy) m_ov = 0;
      end else begin
         acc = v[m_owner] && (!m_ov || ordy);
         if (acc) begin
            m_ov = 1; m_od = int'(d[m_owner*DW +: DW]); m_ol = m_owner; m_olast = l[m_owner];
            rd_cnt[m_owner]++;
            if (l[m_owner]) begin
               m_locked = 0;
               m_ptr = (m_owner + 1) % N;
            end
         end else if (ordy) begin
            m_ov = 0;
         end
      end
   endtask

   // Check the logged transfers against an expected lane/data/last list.
   task automatic chk_log(input string tag, input int n, input int lanes[8],
                          input int datas[8], input int lasts[8]);
      logic [6:0] e;
      chk({tag, "_count"}, 32'(xlog.size()), 32'(n));
      for (int i = 0; i < n && i < xlog.size(); i++) begin
         e = xlog[i];
         chk({tag, "_lane"}, 32'(e[5:4]), 32'(lanes[i]));
         if (datas[i] >= 0) chk({tag, "_data"}, 32'(e[3:0]), 32'(datas[i]));
         if (lasts[i] >= 0) chk({tag, "_last"}, 32'(e[6]),   32'(lasts[i]));
      end
   endtask

   initial begin
      int len;
      bit r;
      logic [N-1:0] en;
      for (int i = 0; i < N; i++) begin wr_cnt[i] = 0; rd_cnt[i] = 0; end
      m_locked = 0; m_owner = 0; m_ptr = 0; m_ov = 0; m_od = 0; m_ol = 0; m_olast = 0;
      cyc = 0;
      rst = 1'b1; out_ready = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
      @(posedge clk);

      // Reset with all lanes valid, then round robin of single-beat bursts
      for (int i = 0; i < N; i++) push(i, i, 1'b1);
      push(0, 0, 1'b1);
      step(1'b1, 1'b1, 4'hF);
      step(1'b1, 1'b1, 4'hF);
      chk("reset_ready", 32'(obs_rdy), 32'(0));
      xlog.delete(); xcyc.delete();
      step(1'b0, 1'b1, 4'hF);
      chk("decision_ready", 32'(obs_rdy), 32'(0));
      step(1'b0, 1'b1, 4'hF);
      chk("first_grant", 32'(obs_rdy), 32'(1));
      repeat (14) step(1'b0, 1'b1, 4'hF);
      chk_log("rr", 5, '{0,1,2,3,0,0,0,0}, '{0,1,2,3,0,0,0,0}, '{1,1,1,1,1,0,0,0});
      if (xcyc.size() >= 2) chk("rr_bubble", 32'(xcyc[1] - xcyc[0]), 32'(2));

      // Single 3-beat burst on lane 2, then pointer should favour lane 3
      step(1'b1, 1'b1, 4'hF);
      flush();
      push(2, 4'hA, 1'b0); push(2, 4'hB, 1'b0); push(2, 4'hC, 1'b1);
      xlog.delete(); xcyc.delete();
      repeat (8) step(1'b0, 1'b1, 4'hF);
      chk_log("burst", 3, '{2,2,2,0,0,0,0,0}, '{10,11,12,0,0,0,0,0}, '{0,0,1,0,0,0,0,0});
      if (xcyc.size() >= 3) chk("burst_back2back", 32'(xcyc[2] - xcyc[0]), 32'(2));
      push(0, 5, 1'b1); push(3, 6, 1'b1);
      xlog.delete(); xcyc.delete();
      repeat (6) step(1'b0, 1'b1, 4'hF);
      chk_log("ptr3", 2, '{3,0,0,0,0,0,0,0}, '{6,5,0,0,0,0,0,0}, '{1,1,0,0,0,0,0,0});

      // Back-pressure mid-burst on lane 1
      push(1, 1, 1'b0); push(1, 2, 1'b0); push(1, 3, 1'b0); push(1, 4, 1'b1);
      xlog.delete(); xcyc.delete();
      repeat (3) step(1'b0, 1'b1, 4'hF);
      repeat (3) begin
         step(1'b0, 1'b0, 4'hF);
         chk("bp_ready", 32'(obs_rdy), 32'(0));
         chk("bp_valid", 32'(obs_ov), 32'(1));
         chk("bp_hold",  32'(obs_od), 32'(2));
      end
      repeat (6) step(1'b0, 1'b1, 4'hF);
      chk_log("bp", 4, '{1,1,1,1,0,0,0,0}, '{1,2,3,4,0,0,0,0}, '{0,0,0,1,0,0,0,0});

      // Lock held while lane 0 drops valid and lane 3 waits
      push(0, 1, 1'b0); push(0, 2, 1'b0); push(0, 3, 1'b1); push(3, 9, 1'b1);
      xlog.delete(); xcyc.delete();
      step(1'b0, 1'b1, 4'b0001);
      step(1'b0, 1'b1, 4'b1001);
      repeat (2) step(1'b0, 1'b1, 4'b1000);
      repeat (8) step(1'b0, 1'b1, 4'b1001);
      chk_log("lock", 4, '{0,0,0,3,0,0,0,0}, '{1,2,3,9,0,0,0,0}, '{0,0,1,1,0,0,0,0});

      // Reset mid-burst on lane 2 (pointer at 2 beforehand)
      push(1, 5, 1'b1);
      push(2, 1, 1'b0); push(2, 2, 1'b0); push(2, 3, 1'b0); push(2, 4, 1'b1);
      repeat (5) step(1'b0, 1'b0, 4'hF);
      chk("pre_rst_valid", 32'(out_valid), 32'(1));
      step(1'b1, 1'b0, 4'hF);
      flush();
      push(0, 7, 1'b1); push(2, 8, 1'b1);
      xlog.delete(); xcyc.delete();
      step(1'b0, 1'b1, 4'hF);
      chk("post_rst_valid", 32'(obs_ov), 32'(0));
      chk("post_rst_busy",  32'(obs_busy), 32'(0));
      repeat (6) step(1'b0, 1'b1, 4'hF);
      chk_log("rst", 2, '{0,2,0,0,0,0,0,0}, '{7,8,0,0,0,0,0,0}, '{1,1,0,0,0,0,0,0});

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < N; i++) begin
            if ((wr_cnt[i] - rd_cnt[i]) < 8 && $urandom_range(0, 3) == 0) begin
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) push(i, $urandom_range(0, 15), b == len - 1);
            end
         end
         r = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 4) != 0);
         step(r, $urandom_range(0, 9) < 7, en);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
